// File: rtl/player_mover.sv
// Player sprite position/colour owner: steps on direction buttons with auto-repeat, wraps at screen edges,
// honours per-rectangle block flags, and cycles colour on each btnC press.
module player_mover #(
  parameter int N_RECT       = 4,
  parameter int PW           = 12,
  parameter int PH           = 12,
  parameter int H_MAX        = 640,
  parameter int V_MAX        = 480,
  parameter int STEP         = 1,
  parameter int H_START      = 314,
  parameter int V_START      = 234,
  parameter int COLOR_INIT   = 0,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic              btnClk,
  input  logic              rst,
  input  logic [3:0]        btns,
  input  logic              btnC,
  input  logic [N_RECT-1:0] up_blk,
  input  logic [N_RECT-1:0] down_blk,
  input  logic [N_RECT-1:0] left_blk,
  input  logic [N_RECT-1:0] right_blk,
  output logic [9:0]        player_hPos,
  output logic [9:0]        player_vPos,
  output logic [3:0]        player_color,
  output logic              moving,
  output logic [3:0]        dir_o
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_RATE - 1);
  localparam logic [10:0]      STEP_W   = 11'(STEP);
  localparam logic [10:0]      H_LIM    = 11'(H_MAX - PW);
  localparam logic [10:0]      V_LIM    = 11'(V_MAX - PH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_last;
  logic [3:0]       dir_q, dir_d;
  logic [9:0]       h_q, h_d, v_q, v_d;
  logic [3:0]       color_q, color_d;
  logic             btnC_q;
  logic             btns_vld;
  logic [3:0]       step_dir;
  logic [10:0]      h_ext, v_ext;

  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= '0;
      h_q     <= 10'(H_START);
      v_q     <= 10'(V_START);
      color_q <= 4'(COLOR_INIT);
      btnC_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      h_q     <= h_d;
      v_q     <= v_d;
      color_q <= color_d;
      btnC_q  <= btnC;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    step_dir = 4'd0;
    btns_vld = (btns == 4'd8) || (btns == 4'd4) || (btns == 4'd2) || (btns == 4'd1);
    cnt_last = (state_q == DELAY) ? DLY_LAST : RPT_LAST;
    case (state_q)
      IDLE: begin
        if (btns_vld) begin
          step_dir = btns;
          dir_d    = btns;
          cnt_d    = '0;
          state_d  = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (!btns_vld) begin
          dir_d   = 4'd0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (btns != dir_q) begin
          // A new direction steps at once and restarts the initial delay.
          step_dir = btns;
          dir_d    = btns;
          cnt_d    = '0;
          state_d  = DELAY;
        end else if (cnt_q == cnt_last) begin
          step_dir = dir_q;
          cnt_d    = '0;
          state_d  = REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Blocked steps leave position untouched but the repeat timing still runs.
  always_comb begin
    h_ext = {1'b0, h_q};
    v_ext = {1'b0, v_q};
    h_d   = h_q;
    v_d   = v_q;
    case (step_dir)
      4'd8: if (!(|up_blk))
              v_d = (v_ext < STEP_W) ? 10'(V_LIM) : 10'(v_ext - STEP_W);
      4'd4: if (!(|down_blk))
              v_d = (v_ext + STEP_W > V_LIM) ? 10'd0 : 10'(v_ext + STEP_W);
      4'd1: if (!(|left_blk))
              h_d = (h_ext < STEP_W) ? 10'(H_LIM) : 10'(h_ext - STEP_W);
      4'd2: if (!(|right_blk))
              h_d = (h_ext + STEP_W > H_LIM) ? 10'd0 : 10'(h_ext + STEP_W);
      default: ;
    endcase
  end

  always_comb begin
    color_d = color_q;
    if (btnC && !btnC_q) color_d = color_q + 4'd1;
  end

  assign player_hPos  = h_q;
  assign player_vPos  = v_q;
  assign player_color = color_q;
  assign moving       = (state_q != IDLE);
  assign dir_o        = dir_q;

endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover: reset, auto-repeat timing, wrap, blocking, direction change, colour.
module tb_player_mover;
  logic       btnClk = 1'b0;
  logic       rst;
  logic [3:0] btns;
  logic       btnC;
  logic [3:0] up_blk, down_blk, left_blk, right_blk;
  logic [9:0] player_hPos, player_vPos;
  logic [3:0] player_color;
  logic       moving;
  logic [3:0] dir_o;

  int checks = 0;
  int errors = 0;

  player_mover dut (
    .btnClk(btnClk), .rst(rst), .btns(btns), .btnC(btnC),
    .up_blk(up_blk), .down_blk(down_blk), .left_blk(left_blk), .right_blk(right_blk),
    .player_hPos(player_hPos), .player_vPos(player_vPos), .player_color(player_color),
    .moving(moving), .dir_o(dir_o)
  );

  always #5 btnClk = ~btnClk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge btnClk);
    #1;
  endtask

  task automatic press(input logic [3:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      btns = d;
      tick();
      btns = 4'd0;
      tick();
    end
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btns = 4'd0; btnC = 1'b0;
    up_blk = '0; down_blk = '0; left_blk = '0; right_blk = '0;
    #12;
    chk("rst_h", player_hPos, 314);
    chk("rst_v", player_vPos, 234);
    chk("rst_color", player_color, 0);
    chk("rst_moving", moving, 0);
    chk("rst_dir", dir_o, 0);
    rst = 1'b0;
    tick();

    btnC = 1'b1; tick(); btnC = 1'b0; tick();
    chk("color_one", player_color, 1);

    // Hold right: steps at cycles 1, 9, 13, 17.
    btns = 4'd2;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("hold_h%0d", i), player_hPos,
          314 + int'(i >= 1) + int'(i >= 9) + int'(i >= 13) + int'(i >= 17));
    end
    chk("hold_moving", moving, 1);
    chk("hold_dir", dir_o, 2);

    // Asynchronous reset mid-repeat.
    #2 rst = 1'b1;
    #1;
    chk("arst_h", player_hPos, 314);
    chk("arst_v", player_vPos, 234);
    chk("arst_color", player_color, 0);
    chk("arst_moving", moving, 0);
    chk("arst_dir", dir_o, 0);
    rst = 1'b0;
    btns = 4'd0;
    tick(); tick(); tick();
    chk("idle_h", player_hPos, 314);
    chk("idle_v", player_vPos, 234);
    chk("idle_moving", moving, 0);

    // Edge wrap in all four directions.
    press(4'd8, 234);
    chk("up_to_0", player_vPos, 0);
    press(4'd8, 1);
    chk("up_wrap", player_vPos, 468);
    press(4'd4, 1);
    chk("down_wrap", player_vPos, 0);
    press(4'd2, 314);
    chk("right_to_628", player_hPos, 628);
    press(4'd2, 1);
    chk("right_wrap", player_hPos, 0);
    press(4'd1, 1);
    chk("left_wrap", player_hPos, 628);
    rst_pulse();

    // Blocked down: timing runs, position frozen until flag clears.
    down_blk = 4'b0100;
    btns = 4'd4;
    tick();
    chk("blk_first", player_vPos, 234);
    repeat (11) tick();
    chk("blk_v", player_vPos, 234);
    chk("blk_moving", moving, 1);
    chk("blk_dir", dir_o, 4);
    down_blk = 4'b0000;
    tick();
    chk("unblk_v", player_vPos, 235);
    btns = 4'd0;
    tick();
    chk("release_moving", moving, 0);
    up_blk = 4'b1111; left_blk = 4'b1111; right_blk = 4'b1111;
    press(4'd4, 1);
    chk("other_blk_v", player_vPos, 236);
    up_blk = '0; left_blk = '0; right_blk = '0;
    rst_pulse();

    // Direction change restarts the initial delay.
    btns = 4'd8;
    repeat (4) tick();
    chk("dc_up_v", player_vPos, 233);
    btns = 4'd1;
    tick();
    chk("dc_left_h", player_hPos, 313);
    chk("dc_dir", dir_o, 1);
    repeat (7) tick();
    chk("dc_wait_h", player_hPos, 313);
    tick();
    chk("dc_rep_h", player_hPos, 312);
    chk("dc_v", player_vPos, 233);
    btns = 4'd0;
    tick();
    rst_pulse();

    // Colour wrap with a held button, concurrent with a step.
    for (int k = 0; k < 15; k++) begin
      btnC = 1'b1; tick(); btnC = 1'b0; tick();
    end
    chk("color_15", player_color, 15);
    btnC = 1'b1; btns = 4'd2;
    tick();
    chk("color_wrap", player_color, 0);
    chk("color_step_h", player_hPos, 315);
    btns = 4'd0;
    repeat (9) tick();
    chk("color_held", player_color, 0);
    btnC = 1'b0;
    btns = 4'b1010;
    tick(); tick(); tick();
    chk("inv_moving", moving, 0);
    chk("inv_dir", dir_o, 0);
    chk("inv_h", player_hPos, 315);
    chk("inv_v", player_vPos, 234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
